// File: rtl/if_prefetch_if.sv
// Bundle of the instruction-memory port, the redirect input and the decode handshake.
// master is the fetch stage's view; slave is the memory/decode/branch side.
interface if_prefetch_if;
    logic        mem_cen_I;
    logic [29:0] mem_addr_I;
    logic [31:0] mem_rdata_I;
    logic        mem_stall_I;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;

    modport master (
        output mem_cen_I, mem_addr_I, inst_valid, inst, inst_pc,
        input  mem_rdata_I, mem_stall_I, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_cen_I, mem_addr_I, inst_valid, inst, inst_pc,
        output mem_rdata_I, mem_stall_I, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch stage: fetches words from instruction memory into a small FIFO
// and hands them to decode; redirects flush the FIFO and can cancel a stalled request.
//
// state  | meaning
// S_IDLE | one cycle after reset, no request
// S_RUN  | normal fetch of fetch_pc while the FIFO has room
// S_KILL | cancelled request held at kill_addr until accepted, word dropped
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input logic            clk,
    input logic            rst_n,
    if_prefetch_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_KILL} state_t;

    state_t            state, state_nxt;
    logic [29:0]       fetch_pc, fetch_pc_nxt;
    logic [29:0]       kill_addr, kill_addr_nxt;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [31:0]       word_q [DEPTH];
    logic [29:0]       pc_q   [DEPTH];
    logic              cen;
    logic [29:0]       addr;
    logic              push, pop, flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            kill_addr <= 30'd0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            kill_addr <= kill_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        kill_addr_nxt = kill_addr;
        cen           = 1'b0;
        addr          = fetch_pc;
        push          = 1'b0;
        flush         = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
                if (bus.redirect_valid)
                    fetch_pc_nxt = bus.redirect_pc;
            end
            S_RUN: begin
                cen = (count < FULL);
                if (bus.redirect_valid) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = bus.redirect_pc;
                    // A stalled request must still be completed with memory, so park it in KILL.
                    if (cen && bus.mem_stall_I) begin
                        kill_addr_nxt = fetch_pc;
                        state_nxt     = S_KILL;
                    end
                end else if (cen && !bus.mem_stall_I) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 30'd1;
                end
            end
            S_KILL: begin
                cen  = 1'b1;
                addr = kill_addr;
                if (bus.redirect_valid) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = bus.redirect_pc;
                end
                if (!bus.mem_stall_I)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pop = (count != '0) && bus.inst_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero before the first fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'd0;
                pc_q[i]   <= 30'd0;
            end
        end else if (push) begin
            word_q[wr_ptr] <= bus.mem_rdata_I;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.mem_cen_I  = cen;
    assign bus.mem_addr_I = addr;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = word_q[rd_ptr];
    assign bus.inst_pc    = pc_q[rd_ptr];
endmodule
